// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the MEPHI CPU: sequences fetch/decode/execute/memory/writeback
// and decodes the datapath strobes, ALU control and memory handshake from the current state.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic [2:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       alucontrol,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_ADDR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_LW   = 4'b0010;
    localparam logic [3:0] OP_SW   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_BNE  = 4'b0101;
    localparam logic [3:0] OP_JMP  = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t           state, state_nx;
    logic [3:0]       op_q;
    logic [2:0]       funct_q;
    logic             halt_entry;
    logic             illegal_q;
    logic             decode_illegal;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            funct_q    <= '0;
            halt_entry <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state      <= state_nx;
            halt_entry <= (state == S_DECODE);
            if (state == S_DECODE) begin
                op_q    <= opcode;
                funct_q <= funct;
            end
            if (decode_illegal) illegal_q <= 1'b1;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        // NOTE: defaults first, so any state that omits a strobe drives 0 instead of a latch.
        state_nx       = state;
        decode_illegal = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        iord           = 1'b0;
        ir_we          = 1'b0;
        pc_we          = 1'b0;
        pc_src         = 2'b00;
        alusrca        = 1'b0;
        alusrcb        = 2'b00;
        alucontrol     = 3'b000;
        reg_we         = 1'b0;
        wb_sel         = 1'b0;
        retire         = 1'b0;
        halted         = 1'b0;
        unique case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                if (mem_ready) begin
                    ir_we    = 1'b1;
                    pc_we    = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed into aluout while the opcode is decoded.
                alusrcb = 2'b11;
                case (opcode)
                    OP_R:           state_nx = S_EXEC_R;
                    OP_ADDI:        state_nx = S_EXEC_I;
                    OP_LW, OP_SW:   state_nx = S_ADDR;
                    OP_BEQ, OP_BNE: state_nx = S_BRANCH;
                    OP_JMP:         state_nx = S_JUMP;
                    OP_HALT:        state_nx = S_HALT;
                    default: begin
                        state_nx       = S_HALT;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alusrca    = 1'b1;
                alucontrol = funct_q;
                state_nx   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                state_nx = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_we   = 1'b1;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_ADDR: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                state_nx = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_nx = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_we   = 1'b1;
                wb_sel   = 1'b1;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b111;
                pc_src     = 2'b01;
                pc_we      = (op_q == OP_BEQ) ? zero : ~zero;
                retire     = 1'b1;
                state_nx   = S_FETCH;
            end
            S_JUMP: begin
                pc_we    = 1'b1;
                pc_src   = 2'b10;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                // Only a genuine HALT retires, and only on its first cycle here.
                retire = halt_entry && (op_q == OP_HALT);
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    assign instret = cnt_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver plays memory/instruction source and pushes
// expected per-instruction behaviour; a monitor pops and checks at each DUT retire.
module tb_multicycle_ctrl;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       opcode;
    logic [2:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0]       pc_src, alusrcb;
    logic             alusrca;
    logic [2:0]       alucontrol;
    logic             reg_we, wb_sel, retire, halted, illegal;
    logic [CNT_W-1:0] instret;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alusrca(alusrca),
        .alusrcb(alusrcb), .alucontrol(alucontrol), .reg_we(reg_we), .wb_sel(wb_sel),
        .retire(retire), .instret(instret), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [2:0] funct;
        logic       zero;
        int         dwait;
    } instr_t;

    typedef struct {
        logic [3:0] op;
        logic [2:0] funct;
        logic       zero;
        int         lat;
        bit         retires;
    } exp_t;

    instr_t prog[$];
    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    int     exp_cnt = 0;
    int     cur_dwait = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [17:0] all_outs();
        return {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alusrca, alusrcb,
                alucontrol, reg_we, wb_sel, retire, halted, illegal};
    endfunction

    // Cycles from the fetch-grant cycle to the retire cycle: zero-wait latency
    // (R/ADDI 4, LW 5, SW 4, BEQ/BNE/JMP 3, HALT 3) minus the fetch cycle, plus data waits.
    function automatic exp_t model(input instr_t i);
        exp_t e;
        e.op = i.op; e.funct = i.funct; e.zero = i.zero;
        e.retires = 1'b1;
        case (i.op)
            4'd0, 4'd1:             e.lat = 4 - 1;
            4'd2:                   e.lat = 5 - 1 + i.dwait;
            4'd3:                   e.lat = 4 - 1 + i.dwait;
            4'd4, 4'd5, 4'd6, 4'd15: e.lat = 3 - 1;
            default: begin e.lat = -1; e.retires = 1'b0; end
        endcase
        return e;
    endfunction

    function automatic instr_t mk(input logic [3:0] op, input logic [2:0] f,
                                  input logic z, input int dw);
        instr_t i;
        i.op = op; i.funct = f; i.zero = z; i.dwait = dw;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        logic [3:0] op;
        op = 4'($urandom_range(0, 6));
        return mk(op, 3'($urandom), 1'($urandom), (op == 4'd2 || op == 4'd3) ? $urandom_range(0, 3) : 0);
    endfunction

    // Driver: memory and instruction source; a new instruction appears on fetch grant.
    initial begin : driver
        int     wait_left;
        bit     busy;
        instr_t ins;
        mem_ready = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
        busy = 1'b0; wait_left = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0;
                mem_ready = 1'b0;
            end else if (mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    wait_left = iord ? cur_dwait : $urandom_range(0, 2);
                end
                if (wait_left > 0) begin
                    wait_left--;
                    mem_ready = 1'b0;
                end else if (!iord && prog.size() == 0) begin
                    mem_ready = 1'b0;
                end else begin
                    mem_ready = 1'b1;
                    busy = 1'b0;
                    if (!iord) begin
                        ins = prog.pop_front();
                        opcode = ins.op; funct = ins.funct; zero = ins.zero;
                        cur_dwait = ins.dwait;
                        exp_q.push_back(model(ins));
                    end
                end
            end else begin
                busy = 1'b0;
                mem_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: checks fetch strobes, execute decode and every retire against the queue.
    initial begin : monitor
        int   cyc;
        exp_t e;
        cyc = 0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                exp_cnt = 0;
                cyc = 0;
            end else begin
                cyc++;
                if (mem_req && !iord && mem_ready) begin
                    check("fetch_strobes", {ir_we, pc_we, pc_src, alusrca, alusrcb, alucontrol, mem_we},
                          {1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0});
                    cyc = 0;
                end
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    if (cyc == 2 && e.op == 4'd0)
                        check("exec_r", {alusrca, alusrcb, alucontrol}, {1'b1, 2'b00, e.funct});
                    if (cyc == 2 && e.op == 4'd1)
                        check("exec_i", {alusrca, alusrcb, alucontrol}, {1'b1, 2'b10, 3'b000});
                    if (mem_req && iord && mem_ready)
                        check("data_we", mem_we, e.op == 4'd3);
                end
                if (retire) begin
                    if (exp_q.size() == 0 || !exp_q[0].retires) begin
                        check("spurious_retire", retire, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("latency", cyc, e.lat);
                        check("instret", instret, exp_cnt % (1 << CNT_W));
                        exp_cnt++;
                        case (e.op)
                            4'd0, 4'd1: check("wb_alu", {reg_we, wb_sel, pc_we, mem_req}, 4'b1000);
                            4'd2:       check("wb_mem", {reg_we, wb_sel, pc_we, mem_req}, 4'b1100);
                            4'd3:       check("mem_wr", {reg_we, mem_req, mem_we, iord}, 4'b0111);
                            4'd4, 4'd5: check("branch", {alucontrol, pc_src, alusrca, alusrcb, pc_we, reg_we},
                                              {3'b111, 2'b01, 1'b1, 2'b00,
                                               (e.op == 4'd4) ? e.zero : ~e.zero, 1'b0});
                            4'd6:       check("jump", {pc_we, pc_src, reg_we}, 4'b1100);
                            default:    check("halt_retire", {halted, reg_we, pc_we, mem_req}, 4'b1000);
                        endcase
                    end
                end
            end
        end
    end

    task automatic drain(input int budget);
        int k = 0;
        while ((prog.size() != 0 || exp_q.size() != 0) && k < budget) begin
            @(negedge clk); k++;
        end
        @(negedge clk); #2;
        check("drain_timeout", k < budget, 1'b1);
    endtask

    task automatic wait_halted(input int budget);
        int k = 0;
        while (!halted && k < budget) begin
            @(negedge clk); #2; k++;
        end
        check("halt_timeout", k < budget, 1'b1);
    endtask

    task automatic reset_and_release();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("reset_outs", all_outs(), '0);
        check("reset_instret", instret, '0);
        prog.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("idle_outs", all_outs(), '0);
    endtask

    initial begin : main
        int k;
        int cnt_snap;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("reset_outs", all_outs(), '0);
        check("reset_instret", instret, '0);
        rst_n = 1'b1;
        #1;
        check("idle_outs", all_outs(), '0);

        prog.push_back(mk(4'd0, 3'b011, 1'b0, 0));
        for (int i = 0; i < 40; i++) prog.push_back(rand_instr());
        prog.push_back(mk(4'd2, 3'b000, 1'b0, 3));
        prog.push_back(mk(4'd4, 3'b000, 1'b1, 0));
        prog.push_back(mk(4'd5, 3'b000, 1'b1, 0));
        drain(3000);

        prog.push_back(mk(4'd15, 3'b000, 1'b0, 0));
        wait_halted(100);
        cnt_snap = exp_cnt;
        repeat (20) @(negedge clk);
        #2;
        check("halt_sticky", {halted, illegal}, 2'b10);
        check("halt_instret", instret, cnt_snap % (1 << CNT_W));

        reset_and_release();
        prog.push_back(mk(4'($urandom_range(7, 14)), 3'b000, 1'b0, 0));
        wait_halted(100);
        repeat (20) @(negedge clk);
        #2;
        check("illegal_sticky", {halted, illegal}, 2'b11);
        check("illegal_instret", instret, exp_cnt % (1 << CNT_W));
        check("illegal_no_retire", exp_q.size(), 1);

        reset_and_release();
        for (int i = 0; i < 3; i++) prog.push_back(mk(4'd6, 3'b000, 1'b0, 0));
        drain(500);
        prog.push_back(mk(4'd3, 3'b000, 1'b0, 10));
        k = 0;
        while (!(mem_req && mem_we) && k < 100) begin
            @(negedge clk); #2; k++;
        end
        check("memwr_timeout", k < 100, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_outs", all_outs(), '0);
        check("midreset_instret", instret, '0);
        prog.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("resume_idle_outs", all_outs(), '0);

        for (int i = 0; i < 20; i++) prog.push_back(mk(4'd6, 3'b000, 1'b0, 0));
        drain(1000);
        check("wrap_instret", instret, exp_cnt % (1 << CNT_W));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
